// File: rtl/if_stage_fetch.sv
// IF stage: PC register, next-PC select, IF/ID pipeline register and run/step/halt control.
// Optional fetched-instruction counter enabled by defining IF_FETCH_COUNT_EN.
module if_stage_fetch #(
   parameter int                   BITS_SIZE   = 32,
   parameter logic [BITS_SIZE-1:0] RESET_PC    = '0,
   parameter logic [5:0]           HALT_OPCODE = 6'b111111
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_enable,
   input  logic                 i_mode_step,
   input  logic                 i_step,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic [1:0]           i_pc_src,
   input  logic [BITS_SIZE-1:0] i_branch_addr,
   input  logic [BITS_SIZE-1:0] i_jump_addr,
   input  logic [BITS_SIZE-1:0] i_jr_addr,
   input  logic [BITS_SIZE-1:0] i_instr,
   output logic [BITS_SIZE-1:0] o_pc,
   output logic [BITS_SIZE-1:0] o_ifid_pc4,
   output logic [BITS_SIZE-1:0] o_ifid_instr,
   output logic                 o_ifid_valid,
   output logic                 o_halted,
   output logic [BITS_SIZE-1:0] o_fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_HALTED
   } state_e;

   localparam logic [BITS_SIZE-1:0] PC_INC     = BITS_SIZE'(4);
   localparam logic [BITS_SIZE-1:0] ALIGN_MASK = ~BITS_SIZE'(3);

   state_e               state_q, state_d;
   logic [BITS_SIZE-1:0] pc_q, pc_d;
   logic [BITS_SIZE-1:0] ifid_pc4_q, ifid_pc4_d;
   logic [BITS_SIZE-1:0] ifid_instr_q, ifid_instr_d;
   logic                 ifid_valid_q, ifid_valid_d;
   logic                 halted_q, halted_d;
   logic                 step_prev_q;

   logic [BITS_SIZE-1:0] pc_plus4;
   logic [BITS_SIZE-1:0] next_pc;
   logic                 step_edge;
   logic                 adv;
   logic                 is_halt;

   always_comb begin
      pc_plus4  = pc_q + PC_INC;
      step_edge = i_step & ~step_prev_q;
      adv       = (state_q == S_RUN) | ((state_q == S_STEP) & step_edge);
      is_halt   = (i_instr[BITS_SIZE-1 -: 6] == HALT_OPCODE);

      unique case (i_pc_src)
         2'b00:   next_pc = pc_plus4;
         2'b01:   next_pc = i_branch_addr;
         2'b10:   next_pc = i_jump_addr;
         default: next_pc = i_jr_addr;
      endcase
      next_pc = next_pc & ALIGN_MASK;
   end

   always_comb begin
      // NOTE: every _d gets a hold default first so no path through the case infers a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (i_enable) state_d = i_mode_step ? S_STEP : S_RUN;
         end
         S_RUN, S_STEP: begin
            // Stall wins over flush and redirect; a step edge seen during stall is simply lost.
            if (adv && !i_stall) begin
               if (i_flush) begin
                  pc_d         = next_pc;
                  ifid_pc4_d   = '0;
                  ifid_instr_d = '0;
                  ifid_valid_d = 1'b0;
               end else begin
                  ifid_pc4_d   = pc_plus4;
                  ifid_instr_d = i_instr;
                  ifid_valid_d = 1'b1;
                  if (is_halt) state_d = S_HALTED;
                  else         pc_d    = next_pc;
               end
            end
         end
         default: begin
            // Drain: keep pushing bubbles behind the HALT while the PC stays frozen.
            ifid_pc4_d   = '0;
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
         end
      endcase

      halted_d = (state_d == S_HALTED);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         ifid_pc4_q   <= '0;
         ifid_instr_q <= '0;
         ifid_valid_q <= 1'b0;
         halted_q     <= 1'b0;
         step_prev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         halted_q     <= halted_d;
         step_prev_q  <= i_step;
      end
   end

   assign o_pc         = pc_q;
   assign o_ifid_pc4   = ifid_pc4_q;
   assign o_ifid_instr = ifid_instr_q;
   assign o_ifid_valid = ifid_valid_q;
   assign o_halted     = halted_q;

`ifdef IF_FETCH_COUNT_EN
   logic [BITS_SIZE-1:0] fetch_count_q, fetch_count_d;

   // Counts exactly the edges that load a real instruction (HALT included).
   always_comb begin
      fetch_count_d = fetch_count_q;
      if (adv && !i_stall && !i_flush) fetch_count_d = fetch_count_q + BITS_SIZE'(1);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) fetch_count_q <= '0;
      else            fetch_count_q <= fetch_count_d;
   end

   assign o_fetch_count = fetch_count_q;
`else
   assign o_fetch_count = '0;
`endif

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- IF stage: program counter register, next-PC selection, and IF/ID pipeline register.
- Drives instruction-memory address; latches fetched instruction and PC+4 for ID.
- ID consumes o_ifid_pc4/o_ifid_instr (jump target build, branch calc) and returns redirect targets here.
- Run/step/halt FSM lets the debug unit run continuously or single-step; fetching HALT stops the stage.

Parameters:
- BITS_SIZE, 32, PC/instruction/address width
- RESET_PC, 0, PC value after reset
- HALT_OPCODE, 6'b111111, opcode (instr[31:26]) treated as HALT

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  debug unit: start execution (sampled in IDLE)
- i_mode_step  in  1  1=single-step, 0=continuous (sampled on IDLE exit)
- i_step  in  1  step request; rising edge = one advance
- i_stall  in  1  hazard stall: hold PC and IF/ID
- i_flush  in  1  insert bubble into IF/ID
- i_pc_src  in  2  00 PC+4, 01 branch, 10 jump, 11 jump-register
- i_branch_addr  in  BITS_SIZE  branch target from ID
- i_jump_addr  in  BITS_SIZE  jump target from ID
- i_jr_addr  in  BITS_SIZE  register target from ID
- i_instr  in  BITS_SIZE  instruction memory read data (async read of o_pc)
- o_pc  out  BITS_SIZE  current PC / instruction memory address
- o_ifid_pc4  out  BITS_SIZE  latched PC+4
- o_ifid_instr  out  BITS_SIZE  latched instruction
- o_ifid_valid  out  1  IF/ID holds a real instruction
- o_halted  out  1  FSM in HALTED
- o_fetch_count  out  BITS_SIZE  fetched-instruction count (optional feature)

Behaviour:
- Reset (async, i_reset_n=0): o_pc=RESET_PC; o_ifid_pc4=0; o_ifid_instr=0 (NOP); o_ifid_valid=0; o_halted=0; state=IDLE; step edge detector cleared; o_fetch_count=0. Reset mid-operation aborts everything immediately.
- FSM: IDLE -> RUN if i_enable & !i_mode_step; IDLE -> STEP if i_enable & i_mode_step; RUN/STEP -> HALTED on a HALT fetch; HALTED is sticky until reset.
- adv = (state==RUN) | (state==STEP & i_step rising edge, registered edge detect: i_step & !i_step_d).
- next_pc: PC+4 / i_branch_addr / i_jump_addr / i_jr_addr by i_pc_src; bits [1:0] forced to 0. PC+4 wraps modulo 2^BITS_SIZE (0xFFFFFFFC -> 0).
- Priority on adv cycle: i_stall > i_flush > normal.
  - i_stall=1: PC and IF/ID hold; redirect and flush ignored. ID re-evaluates the held instruction next cycle.
  - i_flush=1: PC<=next_pc; IF/ID<={0, 0, valid=0}.
  - Normal: PC<=next_pc; IF/ID<={PC+4, i_instr, 1}.
- HALT fetch (normal case, i_instr[31:26]==HALT_OPCODE): HALT latched into IF/ID (valid=1); PC holds at HALT address; state->HALTED; o_halted=1 next cycle. A HALT fetched in a flush cycle is discarded and does not halt.
- HALTED: PC frozen; IF/ID loads a bubble (valid=0) every cycle so the pipeline drains.
- !adv (IDLE, or STEP without an edge): PC and IF/ID hold. A step edge coinciding with stall is consumed (no advance).
- Latency: redirect presented in cycle N -> o_pc shows target after edge N; IF/ID shows that instruction after edge N+1.

Optional Feature:
- Macro IF_FETCH_COUNT_EN.
- Defined: o_fetch_count increments by 1 on every edge loading valid=1 into IF/ID; HALT counted; wraps at 2^BITS_SIZE; reset to 0.
- Undefined: o_fetch_count tied to 0; no counter register.

Test Plan:
- Reset then i_enable=1, i_mode_step=0, i_pc_src=00, instr 0x20010005 everywhere -> o_pc 0,4,8,12 on successive edges; o_ifid_pc4 4,8,12; o_ifid_valid=1 from the second edge.
- In RUN at o_pc=0x10, i_pc_src=10, i_jump_addr=0x40, i_flush=1 -> next o_pc=0x40, o_ifid_valid=0, o_ifid_instr=0; following edge o_ifid_pc4=0x44.
- i_stall=1 with i_pc_src=01, i_flush=1, i_branch_addr=0x80, for 3 cycles -> o_pc and IF/ID unchanged all 3 cycles.
- Step mode: i_step held high 5 cycles, then low, then high -> exactly 2 advances (o_pc 0->4->8).
- HALT 0xFC000000 at 0x0C -> IF/ID gets 0xFC000000, valid=1; o_pc stays 0x0C; o_halted=1; later IF/ID valid=0; with IF_FETCH_COUNT_EN, o_fetch_count=4.
- i_jr_addr=0x00000013, i_pc_src=11 -> o_pc=0x10. Separately, o_pc=0xFFFFFFFC with seq -> o_pc=0. Asserting i_reset_n=0 mid-run -> o_pc=0, state IDLE immediately.
